// File: rtl/heading_driver_pkg.sv
// Shared definitions for the heading driver.
// Contents: the FSM state encoding, the heading, data and counter widths,
// and a helper that forms the 8-bit data word from a 7-bit heading.
package heading_pkg;

    localparam int HEAD_W = 7;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SEND_P = 3'd2,
        ST_GAP    = 3'd3,
        ST_SEND_Q = 3'd4,
        ST_HOLD   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // The top bit of every data word is reserved and always driven low.
    function automatic logic [DATA_W-1:0] make_word(input logic [HEAD_W-1:0] head);
        return {1'b0, head};
    endfunction

endpackage

// File: rtl/heading_driver_if.sv
// Handshake bundle between a command source and the heading driver.
// master: the command source (drives start/abort/headings, sees status).
// slave : the heading driver (sees commands, drives keys, data and status).
interface heading_driver_if;
    import heading_pkg::*;

    logic              start;
    logic              abort;
    logic [HEAD_W-1:0] headP;
    logic [HEAD_W-1:0] headQ;
    logic              request;
    logic              confirm;
    logic [DATA_W-1:0] inputData;
    logic              busy;
    logic              done;
    logic              aborted;

    modport master (
        output start, abort, headP, headQ,
        input  request, confirm, inputData, busy, done, aborted
    );

    modport slave (
        input  start, abort, headP, headQ,
        output request, confirm, inputData, busy, done, aborted
    );

endinterface

// File: rtl/heading_driver_timer.sv
// Down-counter that times each FSM state.
// Ports: clock, reset_n (async, active-low), load/load_value (reload),
// value (current count), zero (count has reached 0).
// Without a load the counter decrements and then rests at 0.
module heading_timer
    import heading_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/heading_driver.sv
// Heading driver: sends a P/Q heading pair to the heading system using the
// request/confirm key protocol.
// Ports: clock, reset_n (async, active-low), hs (heading_driver_if.slave):
//   start/abort/headP/headQ in; request/confirm/inputData/busy/done/aborted out.
// Timing per transfer (cycles): request rises, SETUP cycles later confirm
// pulses PULSE cycles with P, GAP low cycles, PULSE cycles with Q, then HOLD
// cycles of request before release and a one-cycle done.
module heading_driver
    import heading_pkg::*;
#(
    parameter int unsigned SETUP = 1,
    parameter int unsigned PULSE = 1,
    parameter int unsigned GAP   = 1,
    parameter int unsigned HOLD  = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    heading_driver_if.slave hs
);

    // Each state is left on the edge where the counter reads 0, so a state
    // lasting N cycles is loaded with N-1.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD - 1);

    state_t            state_reg;
    logic [HEAD_W-1:0] head_p_reg;
    logic [HEAD_W-1:0] head_q_reg;
    logic              request_reg;
    logic              confirm_reg;
    logic [DATA_W-1:0] data_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              aborted_reg;

    logic              timer_load;
    logic [CNT_W-1:0]  timer_load_value;
    logic [CNT_W-1:0]  timer_value;
    logic              timer_zero;

    logic              abort_now;

    // Abort only bites while a transfer is actually on the wire.
    assign abort_now = hs.abort && (state_reg != ST_IDLE) && (state_reg != ST_DONE);

    heading_timer u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_load_value),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    // Reload the counter with the length of the state being entered.
    always_comb begin
        timer_load       = 1'b0;
        timer_load_value = '0;
        if (state_reg == ST_IDLE) begin
            if (hs.start) begin
                timer_load       = 1'b1;
                timer_load_value = SETUP_LD;
            end
        end else if (abort_now) begin
            timer_load       = 1'b1;
            timer_load_value = '0;
        end else if (timer_zero) begin
            case (state_reg)
                ST_SETUP:  begin timer_load = 1'b1; timer_load_value = PULSE_LD; end
                ST_SEND_P: begin timer_load = 1'b1; timer_load_value = GAP_LD;   end
                ST_GAP:    begin timer_load = 1'b1; timer_load_value = PULSE_LD; end
                ST_SEND_Q: begin timer_load = 1'b1; timer_load_value = HOLD_LD;  end
                default:   begin timer_load = 1'b0; timer_load_value = '0;       end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            head_p_reg  <= '0;
            head_q_reg  <= '0;
            request_reg <= 1'b0;
            confirm_reg <= 1'b0;
            data_reg    <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // Start wins over a simultaneous abort here.
                    if (hs.start) begin
                        head_p_reg  <= hs.headP;
                        head_q_reg  <= hs.headQ;
                        request_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_SETUP;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    if (abort_now) begin
                        request_reg <= 1'b0;
                        confirm_reg <= 1'b0;
                        data_reg    <= '0;
                        busy_reg    <= 1'b0;
                        aborted_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else if (timer_zero) begin
                        case (state_reg)
                            ST_SETUP: begin
                                confirm_reg <= 1'b1;
                                data_reg    <= make_word(head_p_reg);
                                state_reg   <= ST_SEND_P;
                            end
                            ST_SEND_P: begin
                                confirm_reg <= 1'b0;
                                state_reg   <= ST_GAP;
                            end
                            ST_GAP: begin
                                confirm_reg <= 1'b1;
                                data_reg    <= make_word(head_q_reg);
                                state_reg   <= ST_SEND_Q;
                            end
                            ST_SEND_Q: begin
                                confirm_reg <= 1'b0;
                                state_reg   <= ST_HOLD;
                            end
                            ST_HOLD: begin
                                request_reg <= 1'b0;
                                data_reg    <= '0;
                                done_reg    <= 1'b1;
                                state_reg   <= ST_DONE;
                            end
                            default: state_reg <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign hs.request   = request_reg;
    assign hs.confirm   = confirm_reg;
    assign hs.inputData = data_reg;
    assign hs.busy      = busy_reg;
    assign hs.done      = done_reg;
    assign hs.aborted   = aborted_reg;

endmodule

// File: tb/tb_heading_driver.sv
// Bench for heading_driver: one instance with default timing, one with
// SETUP=3 PULSE=2 GAP=2 HOLD=1. Expected per-cycle outputs come from a
// timeline model: cycle k counts from the accepting start edge (k=1 is the
// cycle right after it) and each output is a window over k.
module tb_heading_driver;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    heading_driver_if ifa ();
    heading_driver_if ifb ();

    heading_driver dut_a (
        .clock   (clk),
        .reset_n (reset_n),
        .hs      (ifa)
    );

    heading_driver #(.SETUP(3), .PULSE(2), .GAP(2), .HOLD(1)) dut_b (
        .clock   (clk),
        .reset_n (reset_n),
        .hs      (ifb)
    );

    typedef struct packed {
        logic       req;
        logic       conf;
        logic [7:0] data;
        logic       done;
        logic       busy;
        logic       abrt;
    } obs_t;

    // Expected outputs k cycles after the accepting start edge.
    function automatic obs_t model(input int k, input int s, input int p, input int g,
                                   input int h, input logic [6:0] hp, input logic [6:0] hq);
        obs_t e;
        int   t;
        t      = s + 2 * p + g + h;
        e.req  = (k >= 1 && k <= t);
        e.conf = (k >= s + 1 && k <= s + p) || (k >= s + p + g + 1 && k <= s + 2 * p + g);
        if (k >= s + 1 && k <= s + p + g)
            e.data = {1'b0, hp};
        else if (k >= s + p + g + 1 && k <= t)
            e.data = {1'b0, hq};
        else
            e.data = 8'h00;
        e.done = (k == t + 1);
        e.busy = (k >= 1 && k <= t + 1);
        e.abrt = 1'b0;
        return e;
    endfunction

    function automatic obs_t obs_a();
        return {ifa.request, ifa.confirm, ifa.inputData, ifa.done, ifa.busy, ifa.aborted};
    endfunction

    function automatic obs_t obs_b();
        return {ifb.request, ifb.confirm, ifb.inputData, ifb.done, ifb.busy, ifb.aborted};
    endfunction

    // Protocol monitor on both instances.
    always @(negedge clk) begin
        checks++;
        if ((ifa.confirm && !ifa.request) || (ifb.confirm && !ifb.request))
            $display("FAIL monitor_confirm_without_request a=%b/%b b=%b/%b required confirm<=request",
                     ifa.confirm, ifa.request, ifb.confirm, ifb.request);
        else
            passes++;
        checks++;
        if (ifa.inputData[7] !== 1'b0 || ifb.inputData[7] !== 1'b0)
            $display("FAIL monitor_data_bit7 a=%b b=%b required 0", ifa.inputData[7], ifb.inputData[7]);
        else
            passes++;
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs_a() !== '0) $display("FAIL reset_a actual=%h required=0", obs_a());
        else passes++;
        checks++;
        if (obs_b() !== '0) $display("FAIL reset_b actual=%h required=0", obs_b());
        else passes++;
        $display("reset: outputs a=%h b=%h", obs_a(), obs_b());
    endtask

    // First transfer starts on the very edge after reset release; the first
    // headings are the fixed reference pair, the rest are random.
    task automatic test_transfers();
        logic [6:0] hp, hq;
        obs_t e;
        for (int n = 0; n < 5; n++) begin
            hp = (n == 0) ? 7'b0100100 : 7'($urandom);
            hq = (n == 0) ? 7'b0111000 : 7'($urandom);
            if (n == 0) reset_n = 1'b1;
            ifa.start = 1'b1;
            ifa.headP = hp;
            ifa.headQ = hq;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                e = model(k, 1, 1, 1, 2, hp, hq);
                checks++;
                if (obs_a() !== e)
                    $display("FAIL transfer_a n=%0d k=%0d actual=%h required=%h", n, k, obs_a(), e);
                else
                    passes++;
                if (k == 1) begin
                    ifa.start = 1'b0;
                    ifa.headP = 7'($urandom);
                    ifa.headQ = 7'($urandom);
                end
            end
            $display("transfer_a n=%0d P=%h Q=%h", n, hp, hq);
        end
    endtask

    task automatic test_custom_params();
        logic [6:0] hp, hq;
        obs_t e;
        for (int n = 0; n < 3; n++) begin
            hp = 7'($urandom);
            hq = 7'($urandom);
            ifb.start = 1'b1;
            ifb.headP = hp;
            ifb.headQ = hq;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                e = model(k, 3, 2, 2, 1, hp, hq);
                checks++;
                if (obs_b() !== e)
                    $display("FAIL transfer_b n=%0d k=%0d actual=%h required=%h", n, k, obs_b(), e);
                else
                    passes++;
                if (k == 1) begin
                    ifb.start = 1'b0;
                    ifb.headP = ~hp;
                    ifb.headQ = ~hq;
                end
            end
            $display("transfer_b n=%0d P=%h Q=%h", n, hp, hq);
        end
    endtask

    // start re-pulsed in SEND_P and again in DONE must both be ignored.
    task automatic test_restart_ignored();
        logic [6:0] hp, hq;
        obs_t e;
        int   done_count;
        done_count = 0;
        hp = 7'($urandom);
        hq = 7'($urandom);
        ifa.start = 1'b1;
        ifa.headP = hp;
        ifa.headQ = hq;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            e = model(k, 1, 1, 1, 2, hp, hq);
            checks++;
            if (obs_a() !== e)
                $display("FAIL restart k=%0d actual=%h required=%h", k, obs_a(), e);
            else
                passes++;
            if (ifa.done === 1'b1) done_count++;
            ifa.start = (k == 2 || k == 7);
            ifa.headP = ~hp;
            ifa.headQ = ~hq;
        end
        checks++;
        if (done_count != 1) $display("FAIL restart_done_count actual=%0d required=1", done_count);
        else passes++;
        $display("restart: P=%h Q=%h done pulses=%0d", hp, hq, done_count);
    endtask

    // Abort in GAP, then start together with abort from IDLE.
    task automatic test_abort();
        logic [6:0] hp, hq;
        obs_t e;
        hp = 7'($urandom);
        hq = 7'($urandom);
        ifa.start = 1'b1;
        ifa.headP = hp;
        ifa.headQ = hq;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k <= 3) e = model(k, 1, 1, 1, 2, hp, hq);
            else        e = '0;
            if (k == 4) e.abrt = 1'b1;
            checks++;
            if (obs_a() !== e)
                $display("FAIL abort_gap k=%0d actual=%h required=%h", k, obs_a(), e);
            else
                passes++;
            ifa.start = 1'b0;
            ifa.abort = (k == 3);
        end
        $display("abort: aborted in GAP P=%h Q=%h", hp, hq);
        hp = 7'($urandom);
        hq = 7'($urandom);
        ifa.start = 1'b1;
        ifa.abort = 1'b1;
        ifa.headP = hp;
        ifa.headQ = hq;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            e = model(k, 1, 1, 1, 2, hp, hq);
            checks++;
            if (obs_a() !== e)
                $display("FAIL abort_start_idle k=%0d actual=%h required=%h", k, obs_a(), e);
            else
                passes++;
            ifa.start = 1'b0;
            ifa.abort = 1'b0;
        end
        $display("abort: start with abort accepted P=%h Q=%h", hp, hq);
    endtask

    // Reset dropped in SEND_Q, between clock edges.
    task automatic test_reset_mid();
        logic [6:0] hp, hq;
        obs_t e;
        hp = 7'($urandom);
        hq = 7'($urandom);
        ifa.start = 1'b1;
        ifa.headP = hp;
        ifa.headQ = hq;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            e = model(k, 1, 1, 1, 2, hp, hq);
            checks++;
            if (obs_a() !== e)
                $display("FAIL reset_mid_pre k=%0d actual=%h required=%h", k, obs_a(), e);
            else
                passes++;
            ifa.start = 1'b0;
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs_a() !== '0) $display("FAIL reset_mid_async actual=%h required=0", obs_a());
        else passes++;
        repeat (2) @(negedge clk);
        checks++;
        if (obs_a() !== '0) $display("FAIL reset_mid_held actual=%h required=0", obs_a());
        else passes++;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_a() !== '0) $display("FAIL reset_mid_release actual=%h required=0", obs_a());
        else passes++;
        $display("reset_mid: reset in SEND_Q P=%h Q=%h", hp, hq);
    endtask

    initial begin
        ifa.start = 1'b0; ifa.abort = 1'b0; ifa.headP = '0; ifa.headQ = '0;
        ifb.start = 1'b0; ifb.abort = 1'b0; ifb.headP = '0; ifb.headQ = '0;
        test_reset();
        test_transfers();
        test_custom_params();
        test_restart_ignored();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
